// File: rtl/game_pkg.sv
// Shared types and defaults for the Tetris frame sequencer: op codes, action bit
// positions, controller states and the gravity-period helper.
package game_pkg;

  localparam int GRAV_BASE_DEF = 48;
  localparam int GRAV_STEP_DEF = 4;
  localparam int GRAV_MIN_DEF  = 4;
  localparam int DAS_DELAY_DEF = 10;
  localparam int DAS_RATE_DEF  = 3;

  localparam int ACT_LEFT  = 0;
  localparam int ACT_RIGHT = 1;
  localparam int ACT_ROT   = 2;
  localparam int ACT_DOWN  = 3;
  localparam int ACT_DROP  = 4;

  typedef enum logic [2:0] {
    OP_SPAWN     = 3'd0,
    OP_LEFT      = 3'd1,
    OP_RIGHT     = 3'd2,
    OP_ROTATE    = 3'd3,
    OP_SOFT_DOWN = 3'd4,
    OP_HARD_DROP = 3'd5,
    OP_GRAVITY   = 3'd6,
    OP_CLEAR     = 3'd7
  } op_t;

  typedef enum logic [2:0] {
    ST_START,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_CLEAR,
    ST_SPAWN,
    ST_OVER
  } seq_state_t;

  // Frames between gravity steps; the floor applies once the level would push below it.
  function automatic logic [7:0] grav_period(input logic [3:0] lvl, input int base,
                                             input int step, input int floor_p);
    logic [7:0] drop;
    drop = 8'(lvl) * 8'(step);
    return (drop >= 8'(base - floor_p)) ? 8'(floor_p) : 8'(base) - drop;
  endfunction

endpackage

// File: rtl/game_sequencer_repeat_ctrl.sv
// Delayed auto-repeat for one held key: pulses on the first held tick, again after
// DAS_DELAY held ticks, then every DAS_RATE ticks until released.
module repeat_ctrl #(
  parameter int DAS_DELAY = 10,
  parameter int DAS_RATE  = 3
) (
  input  logic clock,
  input  logic resetn,
  input  logic tick,
  input  logic held,
  output logic fire
);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] held_n;

  always_comb begin
    cnt_d  = cnt_q;
    fire   = 1'b0;
    held_n = cnt_q + 8'd1;
    if (tick) begin
      if (!held) begin
        cnt_d = '0;
      end else begin
        cnt_d = held_n;
        if (held_n == 8'd1 || held_n == 8'(DAS_DELAY + 1)) begin
          fire = 1'b1;
        end else if (held_n == 8'(DAS_DELAY + 1 + DAS_RATE)) begin
          // Fold back to the first repeat point so the count never runs away.
          fire  = 1'b1;
          cnt_d = 8'(DAS_DELAY + 1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_sequencer.sv
// Frame-rate scheduler: derives the frame tick from vsync, keeps gravity and key
// repeat timing, and serialises pending playfield ops over a valid/ready/done link.
module game_sequencer
  import game_pkg::*;
#(
  parameter int GRAV_BASE = GRAV_BASE_DEF,
  parameter int GRAV_STEP = GRAV_STEP_DEF,
  parameter int GRAV_MIN  = GRAV_MIN_DEF,
  parameter int DAS_DELAY = DAS_DELAY_DEF,
  parameter int DAS_RATE  = DAS_RATE_DEF
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       vsync,
  input  logic [4:0] actions,
  input  logic [7:0] score,
  input  logic       gameover,
  input  logic       op_ready,
  input  logic       op_done,
  input  logic       op_landed,
  output logic       op_valid,
  output logic [2:0] op_code,
  output logic       frame_tick,
  output logic [3:0] level,
  output logic       busy
);

  logic       vsync_q, vsync_d;
  logic       tick_q, tick_d;
  logic [3:0] level_q, level_d;
  logic       rot_prev_q, rot_prev_d;
  logic       drop_prev_q, drop_prev_d;
  logic [7:0] grav_cnt_q, grav_cnt_d;
  logic [7:0] pend_q, pend_d;
  seq_state_t state_q, state_d;
  logic       op_valid_q, op_valid_d;
  op_t        op_code_q, op_code_d;
  op_t        cur_op_q, cur_op_d;
  logic       over_req_q, over_req_d;

  logic       accept;
  logic       landed_done;
  logic [7:0] period;
  logic [7:0] pend_set;
  op_t        pick;
  logic [2:0] rep_held, rep_fire;

  // Left and right held together cancel each other and restart both timers.
  assign rep_held[0] = actions[ACT_LEFT] & ~actions[ACT_RIGHT];
  assign rep_held[1] = actions[ACT_RIGHT] & ~actions[ACT_LEFT];
  assign rep_held[2] = actions[ACT_DOWN];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_rep
      repeat_ctrl #(.DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE)) u_rep (
        .clock (clock),
        .resetn(resetn),
        .tick  (tick_q),
        .held  (rep_held[gi]),
        .fire  (rep_fire[gi])
      );
    end
  endgenerate

  assign accept      = op_valid_q & op_ready;
  assign landed_done = (state_q == ST_WAIT_DONE) & op_done & op_landed;
  assign period      = grav_period(level_q, GRAV_BASE, GRAV_STEP, GRAV_MIN);

  always_comb begin
    pick = OP_GRAVITY;
    if (pend_q[OP_SOFT_DOWN]) pick = OP_SOFT_DOWN;
    if (pend_q[OP_RIGHT])     pick = OP_RIGHT;
    if (pend_q[OP_LEFT])      pick = OP_LEFT;
    if (pend_q[OP_ROTATE])    pick = OP_ROTATE;
    if (pend_q[OP_HARD_DROP]) pick = OP_HARD_DROP;
  end

  always_comb begin
    vsync_d     = vsync;
    tick_d      = vsync & ~vsync_q;
    level_d     = 4'(score >> 4);
    rot_prev_d  = rot_prev_q;
    drop_prev_d = drop_prev_q;
    grav_cnt_d  = grav_cnt_q;
    pend_set    = '0;

    if (tick_q) begin
      rot_prev_d  = actions[ACT_ROT];
      drop_prev_d = actions[ACT_DROP];
      if (grav_cnt_q >= period - 8'd1) begin
        grav_cnt_d           = '0;
        pend_set[OP_GRAVITY] = 1'b1;
      end else begin
        grav_cnt_d = grav_cnt_q + 8'd1;
      end
    end
    if (landed_done) grav_cnt_d = '0;

    pend_set[OP_LEFT]      = rep_fire[0];
    pend_set[OP_RIGHT]     = rep_fire[1];
    pend_set[OP_SOFT_DOWN] = rep_fire[2];
    pend_set[OP_ROTATE]    = tick_q & actions[ACT_ROT] & ~rot_prev_q;
    pend_set[OP_HARD_DROP] = tick_q & actions[ACT_DROP] & ~drop_prev_q;

    state_d    = state_q;
    op_valid_d = op_valid_q;
    op_code_d  = op_code_q;
    cur_op_d   = cur_op_q;
    over_req_d = over_req_q;
    pend_d     = pend_q;

    case (state_q)
      ST_START, ST_ISSUE, ST_CLEAR, ST_SPAWN: begin
        if (accept) begin
          state_d    = ST_WAIT_DONE;
          op_valid_d = 1'b0;
          cur_op_d   = op_code_q;
          over_req_d = gameover;
          if (state_q == ST_ISSUE) pend_d[op_code_q] = 1'b0;
        end else if (gameover) begin
          state_d    = ST_OVER;
          op_valid_d = 1'b0;
        end else if (!op_valid_q) begin
          op_valid_d = 1'b1;
          if (state_q == ST_CLEAR)      op_code_d = OP_CLEAR;
          else if (state_q == ST_ISSUE) op_code_d = pick;
          else                          op_code_d = OP_SPAWN;
        end
      end
      ST_IDLE: begin
        if (gameover) begin
          state_d = ST_OVER;
        end else if (|pend_q) begin
          state_d    = ST_ISSUE;
          op_valid_d = 1'b1;
          op_code_d  = pick;
        end
      end
      ST_WAIT_DONE: begin
        if (gameover) over_req_d = 1'b1;
        if (op_done) begin
          over_req_d = 1'b0;
          if (gameover | over_req_q)    state_d = ST_OVER;
          else if (cur_op_q == OP_CLEAR) state_d = ST_SPAWN;
          else if (cur_op_q == OP_SPAWN) state_d = ST_IDLE;
          else if (op_landed)            state_d = ST_CLEAR;
          else                           state_d = ST_IDLE;
        end
      end
      ST_OVER: begin
        op_valid_d = 1'b0;
      end
      default: begin
        state_d    = ST_START;
        op_valid_d = 1'b0;
      end
    endcase

    // A fresh request on the accept cycle must survive the clear above.
    pend_d = pend_d | pend_set;
    if (state_q == ST_OVER) pend_d = '0;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      vsync_q     <= 1'b0;
      tick_q      <= 1'b0;
      level_q     <= '0;
      rot_prev_q  <= 1'b0;
      drop_prev_q <= 1'b0;
      grav_cnt_q  <= '0;
      pend_q      <= '0;
      state_q     <= ST_START;
      op_valid_q  <= 1'b0;
      op_code_q   <= OP_SPAWN;
      cur_op_q    <= OP_SPAWN;
      over_req_q  <= 1'b0;
    end else begin
      vsync_q     <= vsync_d;
      tick_q      <= tick_d;
      level_q     <= level_d;
      rot_prev_q  <= rot_prev_d;
      drop_prev_q <= drop_prev_d;
      grav_cnt_q  <= grav_cnt_d;
      pend_q      <= pend_d;
      state_q     <= state_d;
      op_valid_q  <= op_valid_d;
      op_code_q   <= op_code_d;
      cur_op_q    <= cur_op_d;
      over_req_q  <= over_req_d;
    end
  end

  assign op_valid   = op_valid_q;
  assign op_code    = op_code_q;
  assign frame_tick = tick_q;
  assign level      = level_q;
  assign busy       = (state_q == ST_ISSUE) || (state_q == ST_WAIT_DONE) ||
                      (state_q == ST_CLEAR) || (state_q == ST_SPAWN);

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: a frame-level reference model queues the
// expected op stream, an engine model answers the handshake, a monitor checks accepts.
module tb_game_sequencer;

  localparam int GRAV_BASE = 48;
  localparam int GRAV_STEP = 4;
  localparam int GRAV_MIN  = 4;
  localparam int DAS_DELAY = 10;
  localparam int DAS_RATE  = 3;

  localparam int C_SPAWN = 0, C_LEFT = 1, C_RIGHT = 2, C_ROTATE = 3;
  localparam int C_SOFT = 4, C_DROP = 5, C_GRAV = 6, C_CLEAR = 7;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       vsync = 1'b0;
  logic [4:0] actions = '0;
  logic [7:0] score = 8'h35;
  logic       gameover = 1'b0;
  logic       op_ready, op_done, op_landed;
  logic       op_valid;
  logic [2:0] op_code;
  logic       frame_tick;
  logic [3:0] level;
  logic       busy;

  always #5 clock = ~clock;

  game_sequencer #(
    .GRAV_BASE(GRAV_BASE), .GRAV_STEP(GRAV_STEP), .GRAV_MIN(GRAV_MIN),
    .DAS_DELAY(DAS_DELAY), .DAS_RATE(DAS_RATE)
  ) dut (
    .clock(clock), .resetn(resetn), .vsync(vsync), .actions(actions), .score(score),
    .gameover(gameover), .op_ready(op_ready), .op_done(op_done), .op_landed(op_landed),
    .op_valid(op_valid), .op_code(op_code), .frame_tick(frame_tick), .level(level),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int acc_count = 0;
  bit land_drop = 1'b1;
  bit land_grav = 1'b0;
  int hold_delay = 0;

  // Reference model state: consecutive held ticks per repeat key, last sampled
  // edge keys, ticks since the last gravity step or landing.
  int n_l, n_r, n_d, grav_since;
  bit prev_rot, prev_drop;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit rep_fires(input int n);
    return (n == 1) || (n > DAS_DELAY && ((n - 1 - DAS_DELAY) % DAS_RATE) == 0);
  endfunction

  function automatic int ref_period(input int sc);
    int drop;
    drop = (sc / 16) * GRAV_STEP;
    return (drop >= GRAV_BASE - GRAV_MIN) ? GRAV_MIN : GRAV_BASE - drop;
  endfunction

  task automatic model_reset;
    n_l = 0; n_r = 0; n_d = 0; grav_since = 0; prev_rot = 0; prev_drop = 0;
  endtask

  task automatic model_frame(input logic [4:0] a, input int sc);
    bit f_l, f_r, f_d, f_rot, f_drop, f_grav;
    f_l = 0; f_r = 0;
    if (a[0] && a[1]) begin
      n_l = 0; n_r = 0;
    end else begin
      n_l = a[0] ? n_l + 1 : 0;
      n_r = a[1] ? n_r + 1 : 0;
      f_l = a[0] && rep_fires(n_l);
      f_r = a[1] && rep_fires(n_r);
    end
    n_d    = a[3] ? n_d + 1 : 0;
    f_d    = a[3] && rep_fires(n_d);
    f_rot  = a[2] && !prev_rot;
    f_drop = a[4] && !prev_drop;
    prev_rot = a[2];
    prev_drop = a[4];
    grav_since++;
    f_grav = 0;
    if (grav_since >= ref_period(sc)) begin
      f_grav = 1; grav_since = 0;
    end
    if (f_drop) begin
      exp_q.push_back(C_DROP);
      if (land_drop) begin
        exp_q.push_back(C_CLEAR); exp_q.push_back(C_SPAWN); grav_since = 0;
      end
    end
    if (f_rot) exp_q.push_back(C_ROTATE);
    if (f_l)   exp_q.push_back(C_LEFT);
    if (f_r)   exp_q.push_back(C_RIGHT);
    if (f_d)   exp_q.push_back(C_SOFT);
    if (f_grav) begin
      exp_q.push_back(C_GRAV);
      if (land_grav) begin
        exp_q.push_back(C_CLEAR); exp_q.push_back(C_SPAWN); grav_since = 0;
      end
    end
  endtask

  // Engine model: random ready, done 1-4 cycles after accept (or hold_delay).
  initial begin
    int  done_wait;
    bit  land, acc;
    logic [2:0] code;
    done_wait = -1; land = 0;
    op_ready = 0; op_done = 0; op_landed = 0;
    forever begin
      @(negedge clock);
      acc  = resetn && op_valid && op_ready;
      code = op_code;
      @(posedge clock); #1;
      op_done = 0; op_landed = 0;
      if (acc) begin
        op_ready  = 0;
        done_wait = (hold_delay > 0) ? hold_delay : int'($urandom_range(0, 3));
        land = (int'(code) == C_DROP && land_drop) || (int'(code) == C_GRAV && land_grav);
      end else if (done_wait > 0) begin
        done_wait--;
      end else if (done_wait == 0) begin
        op_done = 1; op_landed = land; done_wait = -1;
      end else begin
        op_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor: every accepted op is popped from the scoreboard and compared.
  bit prev_acc, prev_hold;
  logic [2:0] prev_code;
  initial begin
    int e;
    prev_acc = 0; prev_hold = 0; prev_code = '0;
    forever begin
      @(negedge clock);
      if (!resetn) begin
        prev_acc = 0; prev_hold = 0;
      end else begin
        if (prev_acc) chk("valid_drop_after_accept", int'(op_valid), 0);
        if (prev_hold) begin
          chk("valid_held", int'(op_valid), 1);
          chk("code_stable", int'(op_code), int'(prev_code));
        end
        if (op_valid && op_ready) begin
          acc_count++;
          if (exp_q.size() == 0) begin
            chk("unexpected_op", int'(op_code), -1);
          end else begin
            e = exp_q.pop_front();
            chk("op_code", int'(op_code), e);
            $display("op accepted: code=%0d expected=%0d pending=%0d", op_code, e, exp_q.size());
          end
        end
        prev_acc  = op_valid && op_ready;
        prev_hold = op_valid && !op_ready;
        prev_code = op_code;
      end
    end
  end

  task automatic pulse_vsync;
    @(posedge clock); #1 vsync = 1;
    @(posedge clock);
    @(negedge clock); chk("tick_hi", int'(frame_tick), 1);
    @(posedge clock); #1 vsync = 0;
    @(negedge clock); chk("tick_lo", int'(frame_tick), 0);
  endtask

  task automatic drain;
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy || op_valid) && t < 600) begin
      @(negedge clock); t++;
    end
    checks++;
    if (t >= 600) begin
      errors++;
      $display("FAIL drain_timeout: %0d ops still expected, busy=%0d", exp_q.size(), busy);
      exp_q.delete();
    end
    repeat (6) @(negedge clock);
  endtask

  task automatic do_frame(input logic [4:0] a);
    actions = a;
    model_frame(a, int'(score));
    pulse_vsync();
    drain();
    chk("level", int'(level), int'(score) / 16);
  endtask

  task automatic reset_pulse;
    @(posedge clock); #1 resetn = 0;
    @(posedge clock); #1 resetn = 1;
    @(negedge clock);
    chk("rst_op_valid", int'(op_valid), 0);
    chk("rst_op_code", int'(op_code), 0);
    chk("rst_frame_tick", int'(frame_tick), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clock);
    chk("spawn_cycle1_valid", int'(op_valid), 1);
    chk("spawn_cycle1_code", int'(op_code), C_SPAWN);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] a;
    int base, t;
    model_reset();
    repeat (3) @(posedge clock);
    exp_q.push_back(C_SPAWN);
    reset_pulse();
    score = 8'h00;
    drain();
    chk("idle_after_spawn_busy", int'(busy), 0);

    // Gravity at level 0, then at the clamped top level.
    for (int i = 0; i < 97; i++) do_frame(5'b00000);
    score = 8'hF0;
    for (int i = 0; i < 12; i++) do_frame(5'b00000);

    // Auto-repeat on left, then left+right cancellation.
    score = 8'h00;
    for (int i = 0; i < 20; i++) do_frame(5'b00001);
    do_frame(5'b00000);
    for (int i = 0; i < 6; i++) do_frame(5'b00011);
    do_frame(5'b00001);
    do_frame(5'b00000);

    // Priority: drop, rotate and gravity all pending from one tick.
    score = 8'hF0;
    land_drop = 0;
    while (grav_since != ref_period(int'(score)) - 1) do_frame(5'b00000);
    do_frame(5'b10100);
    do_frame(5'b00000);

    // Landing: hard drop locks, CLEAR and SPAWN follow, gravity restarts from 0.
    land_drop = 1;
    do_frame(5'b10000);
    for (int i = 0; i < 6; i++) do_frame(5'b00000);

    // Randomised play.
    a = '0;
    for (int i = 0; i < 60; i++) begin
      if (i % 10 == 0) begin
        case ($urandom_range(0, 4))
          0: score = 8'h00;
          1: score = 8'h10;
          2: score = 8'h50;
          3: score = 8'hB0;
          default: score = 8'hF0;
        endcase
      end
      land_grav = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 3) == 0) a[b] = ~a[b];
      do_frame(a);
    end
    land_grav = 0;
    do_frame(5'b00000);

    // Game over during WAIT_DONE: the op finishes first, then nothing more is issued.
    score = 8'h00;
    do_frame(5'b10000);
    hold_delay = 12;
    base = acc_count;
    actions = 5'b00100;
    model_frame(5'b00100, int'(score));
    pulse_vsync();
    t = 0;
    while (acc_count == base && t < 200) begin
      @(negedge clock); t++;
    end
    chk("gov_op_accepted", acc_count - base, 1);
    @(posedge clock); #1 gameover = 1;
    repeat (3) @(negedge clock);
    chk("gov_still_waiting_busy", int'(busy), 1);
    t = 0;
    while (busy && t < 60) begin
      @(negedge clock); t++;
    end
    chk("gov_over_busy", int'(busy), 0);
    chk("gov_queue_empty", exp_q.size(), 0);
    hold_delay = 0;
    score = 8'hF0;
    for (int i = 0; i < 100; i++) begin
      actions = 5'($urandom);
      pulse_vsync();
      repeat (10) @(negedge clock);
      chk("over_no_valid", int'(op_valid), 0);
    end

    // Reset out of OVER restarts with SPAWN.
    gameover = 0;
    actions = '0;
    score = 8'h00;
    model_reset();
    exp_q.push_back(C_SPAWN);
    reset_pulse();
    drain();
    chk("post_reset_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) do_frame(5'b00001);
    do_frame(5'b00000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Frame-rate scheduler for the Tetris playfield engine. It turns VGA `vsync` into a one-cycle frame tick, runs gravity timing and input auto-repeat, and serialises all playfield operations into one op stream with a valid/ready/done handshake. It sits between the action inputs, `vsync` from `vga_control`, and `tetriminogeneration`, which executes ops on the frame buffer.

## Interface
Parameters:
- `GRAV_BASE`, 48: gravity period in frames at level 0.
- `GRAV_STEP`, 4: frames removed from the period per level.
- `GRAV_MIN`, 4: floor for the gravity period.
- `DAS_DELAY`, 10: frames a move key is held before auto-repeat starts.
- `DAS_RATE`, 3: frames between auto-repeat moves.

Ports:
- `clock`  in  1  system clock; the only clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `vsync`  in  1  vsync level from `vga_control`, same clock domain.
- `actions`  in  5  key levels: [0] left, [1] right, [2] rotate, [3] soft down, [4] hard drop.
- `score`  in  8  current score from the engine.
- `gameover`  in  1  engine game-over level.
- `op_ready`  in  1  engine accepts the presented op.
- `op_done`  in  1  one-cycle pulse when the accepted op has completed.
- `op_landed`  in  1  qualifies `op_done`; the piece locked.
- `op_valid`  out  1  an op is presented.
- `op_code`  out  3  op: 0 SPAWN, 1 LEFT, 2 RIGHT, 3 ROTATE, 4 SOFT_DOWN, 5 HARD_DROP, 6 GRAVITY, 7 CLEAR.
- `frame_tick`  out  1  one-cycle pulse per `vsync` rising edge.
- `level`  out  4  current level, `score >> 4`.
- `busy`  out  1  high in ISSUE, WAIT_DONE, CLEAR and SPAWN.

## Operation
- **Frame tick:** `vsync` is registered once; `frame_tick` = `vsync & ~vsync_q`.
- **Gravity:**
  - Period = `GRAV_BASE - level*GRAV_STEP`, clamped to `GRAV_MIN` when `level*GRAV_STEP >= GRAV_BASE-GRAV_MIN`.
  - Compute in 8 bits, unsigned.
  - A frame counter increments on each tick. When it reaches period-1 it clears and sets `pend_grav`.
  - The counter clears whenever an op with `op_landed` completes.
- **Input sampling:** `actions` is sampled only on `frame_tick`.
  - Rotate and hard drop are edge-triggered: a 0->1 transition sets the pending flag.
  - Left, right and down use auto-repeat. The first held frame sets the pending flag. After `DAS_DELAY` held frames, the flag is set every `DAS_RATE` frames. Release resets the repeat timer.
  - Left and right held together: neither sets pending, and both repeat timers reset.
- **Pending flags:**
  - One bit per op type; a repeated set while already pending coalesces.
  - A flag clears on the cycle its op is accepted (`op_valid & op_ready`).
- **Priority:** HARD_DROP > ROTATE > LEFT/RIGHT > SOFT_DOWN > GRAVITY.
- **State machine:**
  - START: present SPAWN. On accept -> WAIT_DONE.
  - IDLE: if any flag is pending -> ISSUE.
  - ISSUE: present the highest-priority pending op. On accept -> WAIT_DONE.
  - WAIT_DONE: on `op_done`:
    - `op_landed=1` -> CLEAR.
    - otherwise -> IDLE.
    - if the op was SPAWN or CLEAR, apply the rules below.
  - CLEAR: present CLEAR. On accept -> WAIT_DONE. Its `op_done` -> SPAWN.
  - SPAWN: present SPAWN. On accept -> WAIT_DONE. Its `op_done` -> IDLE.
  - OVER: no ops are presented; all pending flags are held at 0.
- **Game over:** `gameover=1` in any state moves to OVER on the next edge, except while an op is accepted and not yet done; then OVER is entered after `op_done`. OVER is left only by reset.
- **Reset mid-operation:** all state is discarded; the block re-enters START.

## Timing
- Reset values: `op_valid=0`, `op_code=0`, `frame_tick=0`, `level=0`, `busy=0`, state START, counters 0, pending 0.
- `frame_tick` occurs 1 cycle after the `vsync` rising edge is sampled.
- Pending flags are set on the `frame_tick` cycle.
- `op_valid` is registered, at the earliest 1 cycle after a flag sets.
- `op_code` is stable while `op_valid & ~op_ready`.
- `op_valid` drops the cycle after accept.
- Higher-priority flags arriving while an op is presented do not preempt it.
- A tick during WAIT_DONE still updates counters and flags.
- An `op_done` without an outstanding accept is ignored.

## Structure
- Package `game_pkg` holds:
  - op code enum `op_t`;
  - action bit index constants;
  - state enum `seq_state_t`;
  - the default parameter values.
- Sub-module `repeat_ctrl` (held level plus tick in, pulse out, `DAS_DELAY`/`DAS_RATE` parameters) is instantiated for left, right and down.

## Test plan
- **Reset and spawn:** release reset with `op_ready=1` -> `op_valid` with `op_code=0` on cycle 1; after `op_done`, state is IDLE and `busy=0`.
- **Gravity:** `score=0`, no keys -> GRAVITY issued every 48 ticks. `score=0xF0` -> GRAVITY every 4 ticks (clamp).
- **Auto-repeat:** hold left for 20 ticks -> LEFT on ticks 1, 11, 14, 17, 20. Hold left+right -> no move ops.
- **Priority:** rotate edge, drop edge and gravity pending on the same tick -> HARD_DROP, then ROTATE, then GRAVITY, one per handshake.
- **Landing sequence:** `op_done` with `op_landed=1` after HARD_DROP -> CLEAR, then SPAWN, and the gravity counter is 0.
- **Game over and reset:** `gameover=1` while WAIT_DONE -> OVER after `op_done`; `op_valid` stays 0 for 100 ticks. `resetn` low for 1 cycle -> SPAWN is presented again.
